fetch_sequencer: RTL and testbench

Fetch/execute sequencer for the nic8 CPU. It owns the program counter and instruction register, and presents the ROM address. Each instruction takes two phases: a FETCH cycle loads the IR, and an EXEC cycle enables the instruction decoder's register triggers. It also supplies run/halt/single-step debug control, a retired-instruction counter and self-jump hang detection.

---
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer for the nic8 CPU: owns PC and IR, drives the ROM address,
// and provides run/halt/single-step control, a retired-instruction counter and hang detection.
module fetch_sequencer #(
    parameter int unsigned           PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter int unsigned           CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic [7:0]           rom_data,
    input  logic [7:0]           bus_in,
    input  logic                 denyFetch,
    input  logic                 doJumpBar,
    output logic [PC_WIDTH-1:0]  rom_addr,
    output logic [7:0]           ir,
    output logic                 exec_en,
    output logic                 halted,
    output logic                 hung,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } seqState_t;

    seqState_t           state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] iaddr;
    logic                single;

    logic                jumpTaken;
    logic [PC_WIDTH-1:0] jumpTarget;

    assign jumpTaken  = !doJumpBar;
    assign jumpTarget = PC_WIDTH'(bus_in);

    assign rom_addr = pc;
    assign exec_en  = (state == EXEC);
    assign halted   = (state == HALT);

    // Sequencer state, PC/IR, counter and hang flag; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HALT;
            pc      <= RESET_PC;
            ir      <= 8'h00;
            hung    <= 1'b0;
            retired <= '0;
            single  <= 1'b0;
            iaddr   <= RESET_PC;
        end else begin
            case (state)
                HALT: begin
                    // A hung core only accepts single steps.
                    if (run && !hung) begin
                        state  <= FETCH;
                        single <= 1'b0;
                    end else if (step) begin
                        state  <= FETCH;
                        single <= 1'b1;
                    end
                end

                FETCH: begin
                    ir    <= rom_data;
                    iaddr <= pc;
                    pc    <= pc + PC_WIDTH'(1);
                    state <= EXEC;
                end

                EXEC: begin
                    // Jump beats operand skip; an immediate jump's target is the operand itself.
                    if (jumpTaken) begin
                        pc <= jumpTarget;
                    end else if (denyFetch) begin
                        pc <= pc + PC_WIDTH'(1);
                    end
                    retired <= retired + CNT_WIDTH'(1);

                    if (jumpTaken && (jumpTarget == iaddr)) begin
                        hung   <= 1'b1;
                        single <= 1'b0;
                        state  <= HALT;
                    end else if (single || !run) begin
                        single <= 1'b0;
                        state  <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                end

                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural ROM.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [7:0]  rom_data;
    logic [7:0]  bus_in;
    logic        denyFetch;
    logic        doJumpBar;
    logic [7:0]  rom_addr;
    logic [7:0]  ir;
    logic        exec_en;
    logic        halted;
    logic        hung;
    logic [15:0] retired;

    logic [7:0] rom [256];

    int vectors;
    int miscompares;

    fetch_sequencer #(
        .PC_WIDTH  (8),
        .RESET_PC  (8'h00),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .rom_data  (rom_data),
        .bus_in    (bus_in),
        .denyFetch (denyFetch),
        .doJumpBar (doJumpBar),
        .rom_addr  (rom_addr),
        .ir        (ir),
        .exec_en   (exec_en),
        .halted    (halted),
        .hung      (hung),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        reset     = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        bus_in    = 8'h00;
        denyFetch = 1'b0;
        doJumpBar = 1'b1;

        // Reset state and basic free-run
        rom[0] = 8'h12;
        rom[1] = 8'h23;
        tick();
        check("rst_halted",  32'(halted),   32'h1);
        check("rst_exec_en", 32'(exec_en),  32'h0);
        check("rst_pc",      32'(rom_addr), 32'h00);
        check("rst_ir",      32'(ir),       32'h00);
        check("rst_hung",    32'(hung),     32'h0);
        check("rst_retired", 32'(retired),  32'h0);
        reset = 1'b0;
        run   = 1'b1;
        tick();
        check("run_fetch_halted", 32'(halted),  32'h0);
        check("run_fetch_exec",   32'(exec_en), 32'h0);
        tick();
        check("run_exec1_en", 32'(exec_en),  32'h1);
        check("run_exec1_ir", 32'(ir),       32'h12);
        check("run_exec1_pc", 32'(rom_addr), 32'h01);
        tick();
        check("run_fetch2_exec", 32'(exec_en), 32'h0);
        tick();
        check("run_exec2_ir", 32'(ir),       32'h23);
        check("run_exec2_pc", 32'(rom_addr), 32'h02);
        tick();
        check("run_retired2", 32'(retired), 32'h2);

        // Immediate operand skip
        run = 1'b0;
        do_reset();
        rom[0] = 8'h21;
        rom[1] = 8'h99;
        rom[2] = 8'h55;
        run = 1'b1;
        tick();
        tick();
        check("imm_ir", 32'(ir), 32'h21);
        denyFetch = 1'b1;
        tick();
        denyFetch = 1'b0;
        check("imm_pc",      32'(rom_addr), 32'h02);
        check("imm_retired", 32'(retired),  32'h1);
        tick();
        check("imm_next_ir", 32'(ir), 32'h55);

        // Jump wins over operand skip
        rom[8'h40] = 8'h77;
        doJumpBar = 1'b0;
        denyFetch = 1'b1;
        bus_in    = 8'h40;
        tick();
        doJumpBar = 1'b1;
        denyFetch = 1'b0;
        check("jmp_pc",   32'(rom_addr), 32'h40);
        check("jmp_hung", 32'(hung),     32'h0);
        tick();
        check("jmp_ir", 32'(ir), 32'h77);

        // Self-jump at 05
        rom[5] = 8'hA5;
        doJumpBar = 1'b0;
        bus_in    = 8'h05;
        tick();
        doJumpBar = 1'b1;
        tick();
        check("self_ir", 32'(ir), 32'hA5);
        doJumpBar = 1'b0;
        bus_in    = 8'h05;
        tick();
        doJumpBar = 1'b1;
        check("self_hung",    32'(hung),     32'h1);
        check("self_halted",  32'(halted),   32'h1);
        check("self_pc",      32'(rom_addr), 32'h05);
        check("self_retired", 32'(retired),  32'h4);
        tick();
        tick();
        check("hung_run_ignored", 32'(halted), 32'h1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("hung_step_fetch", 32'(halted), 32'h0);
        tick();
        check("hung_step_exec", 32'(exec_en), 32'h1);
        tick();
        check("hung_step_halt",    32'(halted),   32'h1);
        check("hung_step_retired", 32'(retired),  32'h5);
        check("hung_step_pc",      32'(rom_addr), 32'h06);
        check("hung_sticky",       32'(hung),     32'h1);
        run = 1'b0;
        do_reset();
        check("hung_cleared",   32'(hung),     32'h0);
        check("hung_rst_pc",    32'(rom_addr), 32'h00);
        check("hung_rst_count", 32'(retired),  32'h0);

        // Single step to FF, then step across the wrap
        rom[8'hFF] = 8'h3C;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        doJumpBar = 1'b0;
        bus_in    = 8'hFF;
        tick();
        doJumpBar = 1'b1;
        check("ss1_halted",  32'(halted),   32'h1);
        check("ss1_pc",      32'(rom_addr), 32'hFF);
        check("ss1_retired", 32'(retired),  32'h1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("ss2_fetch", 32'(halted), 32'h0);
        tick();
        check("ss2_ir",      32'(ir),       32'h3C);
        check("ss2_pc_wrap", 32'(rom_addr), 32'h00);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("ss2_halted",  32'(halted),  32'h1);
        check("ss2_retired", 32'(retired), 32'h2);
        tick();
        check("step_not_queued", 32'(halted), 32'h1);

        // run and step together: free-run
        run  = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        check("runstep_free",    32'(halted),  32'h0);
        check("runstep_fetch",   32'(exec_en), 32'h0);
        check("runstep_retired", 32'(retired), 32'h3);

        // Reset in EXEC aborts the instruction
        tick();
        doJumpBar = 1'b0;
        bus_in    = 8'h06;
        tick();
        doJumpBar = 1'b1;
        tick();
        check("mid_pc7",  32'(rom_addr), 32'h07);
        check("mid_exec", 32'(exec_en),  32'h1);
        doJumpBar = 1'b0;
        bus_in    = 8'h06;
        run       = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        doJumpBar = 1'b1;
        check("mid_rst_pc",      32'(rom_addr), 32'h00);
        check("mid_rst_retired", 32'(retired),  32'h0);
        check("mid_rst_halted",  32'(halted),   32'h1);
        check("mid_rst_exec",    32'(exec_en),  32'h0);
        check("mid_rst_hung",    32'(hung),     32'h0);

        // run dropped during FETCH: instruction still completes
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("drop_exec", 32'(exec_en), 32'h1);
        tick();
        check("drop_halted",  32'(halted),   32'h1);
        check("drop_retired", 32'(retired),  32'h1);
        check("drop_pc",      32'(rom_addr), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
